// File: rtl/ddr3_rd_sequencer_pkg.sv
// Shared settings for the DDR3 read sequencer: default burst length,
// command-FSM state encodings and the beat-tagging helper.
package ddr3_rd_sequencer_pkg;

   // Beats returned by the PHY for one READ command.
   localparam int unsigned DEF_BURST_BEATS = 4;

   // Command FSM encodings.
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   // A beat closes the AXI burst when it ends a READ burst and no chunk follows.
   function automatic logic closes_axi_burst(input logic burst_end, input logic rseq);
      return burst_end && !rseq;
   endfunction

endpackage

// File: rtl/ddr3_rd_sequencer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO holding tagged read beats.
// The head word is visible combinationally; it reads as zero while empty.
module ddr3_rd_sequencer_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Storage array; written at the tail pointer.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Wrap-around pointers with an extra bit to tell full from empty.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_en && !empty) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/ddr3_rd_sequencer.sv
// DDR3 read sequencer: turns AXI fetch commands into single-burst READs,
// reserving buffer credits per burst so non-stallable PHY beats always fit,
// and returns the beats tagged with request ID and AXI-burst last.
module ddr3_rd_sequencer
   import ddr3_rd_sequencer_pkg::*;
#(
   parameter int unsigned ADDRS       = 32,
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned REQID       = 4,
   parameter int unsigned BURST_BEATS = DEF_BURST_BEATS,
   parameter int unsigned TAG_DEPTH   = 4,
   parameter int unsigned DATA_DEPTH  = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             mem_fetch_i,
   output logic             mem_accept_o,
   input  logic             mem_rseq_i,
   input  logic [REQID-1:0] mem_reqid_i,
   input  logic [ADDRS-1:0] mem_addr_i,
   output logic             ddr_rdreq_o,
   input  logic             ddr_rdack_i,
   output logic [ADDRS-1:0] ddr_addr_o,
   input  logic             dfi_rvalid_i,
   input  logic [WIDTH-1:0] dfi_rdata_i,
   output logic             mem_valid_o,
   input  logic             mem_ready_i,
   output logic             mem_last_o,
   output logic [REQID-1:0] mem_reqid_o,
   output logic [WIDTH-1:0] mem_data_o,
   output logic             err_o
);
   localparam int unsigned TAW = $clog2(TAG_DEPTH);
   localparam int unsigned TPW = TAW + 1;
   localparam int unsigned BCW = $clog2(BURST_BEATS);
   localparam int unsigned CW  = $clog2(DATA_DEPTH) + 1;
   localparam int unsigned BW  = WIDTH + REQID + 1;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic             accept;
   logic [REQID:0]   tag_mem [TAG_DEPTH];
   logic [TPW-1:0]   tag_wr_ptr;
   logic [TPW-1:0]   tag_rd_ptr;
   logic             tag_empty;
   logic             tag_full;
   logic [REQID-1:0] head_reqid;
   logic             head_rseq;
   logic [BCW-1:0]   beat_cnt;
   logic             beat_wr;
   logic             burst_end;
   logic             out_pop;
   logic [CW-1:0]    credits;
   logic [BW-1:0]    fifo_wdata;
   logic [BW-1:0]    fifo_rdata;
   logic             fifo_empty;
   logic             fifo_full;

   assign tag_empty = (tag_wr_ptr == tag_rd_ptr);
   assign tag_full  = (tag_wr_ptr[TAW] != tag_rd_ptr[TAW]) &&
                      (tag_wr_ptr[TAW-1:0] == tag_rd_ptr[TAW-1:0]);
   assign {head_reqid, head_rseq} = tag_mem[tag_rd_ptr[TAW-1:0]];

   assign beat_wr   = dfi_rvalid_i && !tag_empty;
   assign burst_end = (beat_cnt == BCW'(BURST_BEATS - 1));
   assign out_pop   = !fifo_empty && mem_ready_i;

   assign mem_accept_o = accept;
   assign ddr_rdreq_o  = (state == ST_ISSUE);

   // Command FSM next state; accept only with a free tag and a burst of credits.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_fetch_i && !tag_full && (credits >= CW'(BURST_BEATS)) && !reset) begin
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ddr_rdack_i) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Command FSM state and the held READ address.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         ddr_addr_o <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            ddr_addr_o <= mem_addr_i;
         end
      end
   end

   // Tag storage: {reqid, rseq} per outstanding READ.
   always_ff @(posedge clock) begin
      if (accept) begin
         tag_mem[tag_wr_ptr[TAW-1:0]] <= {mem_reqid_i, mem_rseq_i};
      end
   end

   // Tag pointers, beat position within the head burst, and the sticky error.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_wr_ptr <= '0;
         tag_rd_ptr <= '0;
         beat_cnt   <= '0;
         err_o      <= 1'b0;
      end else begin
         if (accept) begin
            tag_wr_ptr <= tag_wr_ptr + TPW'(1);
         end
         if (beat_wr) begin
            beat_cnt <= beat_cnt + BCW'(1);
            if (burst_end) begin
               tag_rd_ptr <= tag_rd_ptr + TPW'(1);
            end
         end
         if (dfi_rvalid_i && tag_empty) begin
            err_o <= 1'b1;
         end
      end
   end

   // Buffer credits: a burst is reserved on accept, one beat returned per output pop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         credits <= CW'(DATA_DEPTH);
      end else begin
         credits <= credits + CW'(out_pop) - (accept ? CW'(BURST_BEATS) : CW'(0));
      end
   end

   assign fifo_wdata = {closes_axi_burst(burst_end, head_rseq), head_reqid, dfi_rdata_i};

   ddr3_rd_sequencer_sync_fifo #(
      .WIDTH (BW),
      .DEPTH (DATA_DEPTH)
   ) u_data_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (beat_wr),
      .wr_data (fifo_wdata),
      .rd_en   (mem_ready_i),
      .rd_data (fifo_rdata),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign mem_valid_o = !fifo_empty;
   assign {mem_last_o, mem_reqid_o, mem_data_o} = fifo_rdata;

   // Credit accounting must keep the buffer within its depth.
   a_credit_bound: assert property (@(posedge clock) disable iff (reset)
      credits <= CW'(DATA_DEPTH));
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(beat_wr && fifo_full));

endmodule

// File: tb/tb_ddr3_rd_sequencer.sv
// Bench for ddr3_rd_sequencer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ddr3_rd_sequencer;
   localparam int unsigned ADDRS = 32;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned REQID = 4;
   localparam int BB   = 4;
   localparam int TAGD = 4;
   localparam int DD   = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             mem_fetch_i = 1'b0;
   logic             mem_accept_o;
   logic             mem_rseq_i = 1'b0;
   logic [REQID-1:0] mem_reqid_i = '0;
   logic [ADDRS-1:0] mem_addr_i = '0;
   logic             ddr_rdreq_o;
   logic             ddr_rdack_i = 1'b0;
   logic [ADDRS-1:0] ddr_addr_o;
   logic             dfi_rvalid_i = 1'b0;
   logic [WIDTH-1:0] dfi_rdata_i = '0;
   logic             mem_valid_o;
   logic             mem_ready_i = 1'b0;
   logic             mem_last_o;
   logic [REQID-1:0] mem_reqid_o;
   logic [WIDTH-1:0] mem_data_o;
   logic             err_o;

   always #5 clock = ~clock;

   ddr3_rd_sequencer #(
      .ADDRS(ADDRS), .WIDTH(WIDTH), .REQID(REQID),
      .BURST_BEATS(BB), .TAG_DEPTH(TAGD), .DATA_DEPTH(DD)
   ) dut (
      .clock(clock), .reset(reset),
      .mem_fetch_i(mem_fetch_i), .mem_accept_o(mem_accept_o),
      .mem_rseq_i(mem_rseq_i), .mem_reqid_i(mem_reqid_i), .mem_addr_i(mem_addr_i),
      .ddr_rdreq_o(ddr_rdreq_o), .ddr_rdack_i(ddr_rdack_i), .ddr_addr_o(ddr_addr_o),
      .dfi_rvalid_i(dfi_rvalid_i), .dfi_rdata_i(dfi_rdata_i),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_last_o(mem_last_o),
      .mem_reqid_o(mem_reqid_o), .mem_data_o(mem_data_o), .err_o(err_o)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [REQID-1:0] reqid;
      logic             rseq;
   } tag_t;

   typedef struct {
      logic             last;
      logic [REQID-1:0] reqid;
      logic [WIDTH-1:0] data;
   } beat_t;

   // Reference model state (post-edge view).
   tag_t             m_tags[$];
   beat_t            m_out[$];
   int               m_credits;
   int               m_bcnt;
   bit               m_issue;
   logic [ADDRS-1:0] m_addr;
   bit               m_err;

   function automatic void model_reset();
      m_tags.delete();
      m_out.delete();
      m_credits = DD;
      m_bcnt    = 0;
      m_issue   = 1'b0;
      m_addr    = '0;
      m_err     = 1'b0;
   endfunction

   // Compare process: check outputs against the model, then advance it over the next edge.
   initial begin : compare_proc
      bit    exp_acc;
      bit    pop;
      beat_t b;
      tag_t  t;
      model_reset();
      forever begin
         @(negedge clock);
         if (reset) begin
            model_reset();
            check("rst_accept", mem_accept_o, 0);
            check("rst_rdreq",  ddr_rdreq_o, 0);
            check("rst_addr",   ddr_addr_o, 0);
            check("rst_valid",  mem_valid_o, 0);
            check("rst_last",   mem_last_o, 0);
            check("rst_reqid",  mem_reqid_o, 0);
            check("rst_data",   mem_data_o, 0);
            check("rst_err",    err_o, 0);
         end else begin
            exp_acc = !m_issue && mem_fetch_i && (m_tags.size() < TAGD) && (m_credits >= BB);
            check("accept", mem_accept_o, exp_acc);
            check("rdreq",  ddr_rdreq_o, m_issue);
            check("addr",   ddr_addr_o, m_addr);
            check("err",    err_o, m_err);
            check("valid",  mem_valid_o, m_out.size() != 0);
            if (m_out.size() != 0) begin
               check("data",  mem_data_o,  m_out[0].data);
               check("reqid", mem_reqid_o, m_out[0].reqid);
               check("last",  mem_last_o,  m_out[0].last);
            end
            pop = (m_out.size() != 0) && mem_ready_i;
            if (pop) begin
               void'(m_out.pop_front());
               m_credits++;
            end
            if (dfi_rvalid_i) begin
               if (m_tags.size() == 0) begin
                  m_err = 1'b1;
               end else begin
                  b.last  = (m_bcnt == BB - 1) && !m_tags[0].rseq;
                  b.reqid = m_tags[0].reqid;
                  b.data  = dfi_rdata_i;
                  m_out.push_back(b);
                  m_bcnt++;
                  if (m_bcnt == BB) begin
                     m_bcnt = 0;
                     void'(m_tags.pop_front());
                  end
               end
            end
            if (m_issue && ddr_rdack_i) m_issue = 1'b0;
            if (exp_acc) begin
               t.reqid = mem_reqid_i;
               t.rseq  = mem_rseq_i;
               m_tags.push_back(t);
               m_credits -= BB;
               m_addr  = mem_addr_i;
               m_issue = 1'b1;
            end
            check("buffer_bound", (m_out.size() <= DD), 1);
         end
      end
   end

   // Record every beat the downstream consumer takes.
   beat_t seen[$];
   initial begin : monitor_proc
      beat_t b;
      forever begin
         @(negedge clock);
         if (!reset && mem_valid_o && mem_ready_i) begin
            b.last  = mem_last_o;
            b.reqid = mem_reqid_o;
            b.data  = mem_data_o;
            seen.push_back(b);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   int pend      = 0;
   bit ack_taken = 1'b0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      mem_fetch_i  = 1'b0;
      ddr_rdack_i  = 1'b0;
      dfi_rvalid_i = 1'b0;
   endtask

   // One randomized cycle; percentages set how often each input is asserted.
   task automatic step(input int p_fetch, input int p_ack, input int p_phy,
                       input int p_ready, output bit acc);
      if (ack_taken) pend += BB;
      mem_fetch_i  = ($urandom_range(0, 99) < p_fetch);
      mem_addr_i   = $urandom;
      mem_reqid_i  = REQID'($urandom);
      mem_rseq_i   = 1'($urandom);
      ddr_rdack_i  = ddr_rdreq_o && ($urandom_range(0, 99) < p_ack);
      ack_taken    = ddr_rdack_i;
      dfi_rvalid_i = (pend > 0) && ($urandom_range(0, 99) < p_phy);
      dfi_rdata_i  = $urandom;
      if (dfi_rvalid_i) pend--;
      mem_ready_i  = ($urandom_range(0, 99) < p_ready);
      #1 acc = mem_accept_o;
      tick();
   endtask

   // Directed fetch: wait for accept, then ack in the second ISSUE cycle.
   task automatic do_fetch(input logic [ADDRS-1:0] addr, input logic [REQID-1:0] id,
                           input logic rseq, output bit ok);
      int n = 0;
      ok = 1'b0;
      mem_fetch_i = 1'b1;
      mem_addr_i  = addr;
      mem_reqid_i = id;
      mem_rseq_i  = rseq;
      while (n < 50) begin
         #1;
         if (mem_accept_o) begin
            ok = 1'b1;
            break;
         end
         tick();
         n++;
      end
      tick();
      mem_fetch_i = 1'b0;
      tick();
      ddr_rdack_i = 1'b1;
      tick();
      ddr_rdack_i = 1'b0;
   endtask

   task automatic send_beats(input logic [WIDTH-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         dfi_rvalid_i = 1'b1;
         dfi_rdata_i  = base + WIDTH'(i);
         tick();
      end
      dfi_rvalid_i = 1'b0;
   endtask

   task automatic wait_seen(input int n, input int budget, input string name);
      int c = 0;
      while (seen.size() < n && c < budget) begin
         tick();
         c++;
      end
      check(name, (seen.size() >= n) ? 64'(n) : 64'(seen.size()), 64'(n));
   endtask

   task automatic drain(input int cycles);
      bit acc;
      repeat (cycles) step(0, 100, 100, 100, acc);
   endtask

   initial begin : driver
      bit acc;
      bit ok;
      int cnt;

      idle();
      repeat (3) @(posedge clock);
      #1;
      check("lit_rst_rdreq", ddr_rdreq_o, 0);
      check("lit_rst_valid", mem_valid_o, 0);
      check("lit_rst_err",   err_o, 0);
      reset = 1'b0;
      tick();

      // Single fetch, one burst A0..A3.
      seen.delete();
      mem_ready_i = 1'b1;
      mem_fetch_i = 1'b1;
      mem_addr_i  = 32'h100;
      mem_reqid_i = 4'd3;
      mem_rseq_i  = 1'b0;
      #1 check("lit_t1_accept", mem_accept_o, 1);
      tick();
      mem_fetch_i = 1'b0;
      check("lit_t1_rdreq", ddr_rdreq_o, 1);
      check("lit_t1_addr",  ddr_addr_o, 32'h100);
      tick();
      ddr_rdack_i = 1'b1;
      tick();
      ddr_rdack_i = 1'b0;
      check("lit_t1_rdreq_drop", ddr_rdreq_o, 0);
      send_beats(32'hA0, 4);
      wait_seen(4, 20, "lit_t1_count");
      for (int i = 0; i < 4; i++) begin
         if (i < seen.size()) begin
            check("lit_t1_data",  seen[i].data, 32'hA0 + i);
            check("lit_t1_reqid", seen[i].reqid, 3);
            check("lit_t1_last",  seen[i].last, (i == 3));
         end
      end

      // Two chained fetches: last only on the 8th beat.
      seen.delete();
      do_fetch(32'h200, 4'd5, 1'b1, ok);
      check("lit_t2_fetch1", ok, 1);
      do_fetch(32'h240, 4'd5, 1'b0, ok);
      check("lit_t2_fetch2", ok, 1);
      send_beats(32'hB0, 8);
      wait_seen(8, 30, "lit_t2_count");
      for (int i = 0; i < 8; i++) begin
         if (i < seen.size()) begin
            check("lit_t2_data",  seen[i].data, 32'hB0 + i);
            check("lit_t2_reqid", seen[i].reqid, 5);
            check("lit_t2_last",  seen[i].last, (i == 7));
         end
      end

      // Credit exhaustion with the consumer stalled.
      idle();
      cnt = 0;
      repeat (40) begin
         step(100, 100, 100, 0, acc);
         cnt += int'(acc);
      end
      check("lit_credit_fill_accepts", cnt, 4);
      check("lit_fill_valid", mem_valid_o, 1);
      step(0, 100, 100, 100, acc);
      cnt = 0;
      repeat (5) begin
         step(100, 100, 100, 0, acc);
         cnt += int'(acc);
      end
      check("lit_one_pop_blocked", cnt, 0);
      repeat (3) step(0, 100, 100, 100, acc);
      step(100, 100, 100, 0, acc);
      check("lit_fourth_pop_accept", acc, 1);
      drain(80);

      // Tag queue full with the PHY withheld; first returning burst frees it.
      cnt = 0;
      repeat (20) begin
         step(100, 100, 0, 100, acc);
         cnt += int'(acc);
      end
      check("lit_tag_full_accepts", cnt, 4);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         step(100, 100, 100, 100, acc);
         ok = acc;
      end
      check("lit_tag_freed_accept", ok, 1);
      drain(80);

      // Stray beat with nothing outstanding.
      idle();
      dfi_rvalid_i = 1'b1;
      dfi_rdata_i  = 32'hDEAD;
      tick();
      dfi_rvalid_i = 1'b0;
      check("lit_stray_err", err_o, 1);
      check("lit_stray_novalid", mem_valid_o, 0);
      drain(10);
      check("lit_err_sticky", err_o, 1);

      // Reset while issuing with two beats buffered.
      idle();
      mem_ready_i = 1'b0;
      do_fetch(32'h300, 4'd7, 1'b0, ok);
      check("lit_mid_fetch1", ok, 1);
      send_beats(32'hC0, 2);
      mem_fetch_i = 1'b1;
      mem_addr_i  = 32'h340;
      mem_reqid_i = 4'd7;
      mem_rseq_i  = 1'b0;
      #1 check("lit_mid_fetch2", mem_accept_o, 1);
      tick();
      mem_fetch_i = 1'b0;
      check("lit_pre_rst_rdreq", ddr_rdreq_o, 1);
      check("lit_pre_rst_valid", mem_valid_o, 1);
      #1 reset = 1'b1;
      #1;
      check("lit_async_rdreq", ddr_rdreq_o, 0);
      check("lit_async_valid", mem_valid_o, 0);
      tick();
      tick();
      reset     = 1'b0;
      pend      = 0;
      ack_taken = 1'b0;
      send_beats(32'hD0, 2);
      check("lit_late_beat_err", err_o, 1);
      check("lit_late_beat_novalid", mem_valid_o, 0);
      cnt = 0;
      repeat (40) begin
         step(100, 100, 100, 0, acc);
         cnt += int'(acc);
      end
      check("lit_post_rst_credits", cnt, 4);
      drain(80);

      // Randomized traffic against the model.
      repeat (3000) step(50, 60, 75, 60, acc);
      drain(120);
      check("lit_end_empty", mem_valid_o, 0);
      check("lit_end_pend", pend, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
